dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares one single-port synchronous data memory between two requesters:
  - Port A: the 64-bit RISC-V core data port.
  - Port B: the coprocessor/debug IO path, used for program/data loading and inspection.
- Port A has fixed priority. A wait counter guarantees that port B is not starved.
- Accepts one access per cycle, fully pipelined. Read data returns one cycle after acceptance, routed back to the requester that issued the read.

Parameters:
- DATA_W, 64, data width of both ports and memory.
- ADDR_W, 64, byte address width of both ports and memory.
- MAX_WAIT, 4, number of consecutive cycles port B may be refused before it is forced to win; range 1..15.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- a_req  in  1  port A request valid.
- a_we  in  1  port A write (1) / read (0).
- a_addr  in  ADDR_W  port A address.
- a_wdata  in  DATA_W  port A write data.
- a_ready  out  1  port A request accepted this cycle.
- a_rvalid  out  1  port A read data valid.
- a_rdata  out  DATA_W  port A read data.
- b_req, b_we, b_addr, b_wdata  in  1/1/ADDR_W/DATA_W  port B request, same meaning as port A.
- b_ready, b_rvalid, b_rdata  out  1/1/DATA_W  port B accept and response, same meaning as port A.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid the cycle after mem_en=1 with mem_we=0.
- b_forced  out  1  the current grant to B was forced by the wait counter (debug).

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-low.
- Handshake:
  - A request transfers when req=1 and ready=1 in the same cycle.
  - While req=1 and not yet accepted, the requester holds we/addr/wdata stable.
  - A requester may drop req before acceptance; the arbiter has no memory of a withdrawn request other than the counter rules below.
- Grant (combinational from current inputs and state):
  - If b_req=1 and wait_cnt==MAX_WAIT: grant B, with b_forced=1.
  - Else if a_req=1: grant A.
  - Else if b_req=1: grant B.
  - Else: no grant.
  - At most one of a_ready/b_ready is 1 in any cycle.
- Memory drive:
  - mem_en = granted.
  - mem_we/mem_addr/mem_wdata come from the granted port.
  - With no grant, mem_en=0, mem_we=0, and address/data are 0.
- Wait counter (wait_cnt, 4 bits):
  - Cleared when b_ready=1 or b_req=0.
  - Incremented when b_req=1 and b_ready=0.
  - Saturates at MAX_WAIT.
- Read return tracking (state register rd_owner: NONE/A/B):
  - On an accepted read, the next state is the accepting port.
  - On an accepted write or no acceptance, the next state is NONE.
  - When rd_owner=A: a_rvalid=1, a_rdata=mem_rdata. rd_owner=B mirrors this on port B.
  - rvalid is a single-cycle pulse with no backpressure; the requester must capture it.
  - rdata of the non-owning port is 0.
- Latency:
  - Read: accept at cycle N, data at N+1.
  - Write: memory updated at the end of cycle N.
  - Back-to-back accepts every cycle are sustained.
- Ordering:
  - Accesses reach memory in acceptance order.
  - A write accepted at N followed by a read of the same address at N+1 (either port) returns the new data.
- Reset (asserted):
  - rd_owner=NONE, wait_cnt=0.
  - All outputs 0 (a_ready, b_ready, a_rvalid, b_rvalid, rdata, mem_*, b_forced).
  - ready is forced 0 while reset is asserted, even if req=1.
  - Reset mid-read: the pending response is dropped; no rvalid after release.
- Boundary cases:
  - Simultaneous requests with wait_cnt<MAX_WAIT: A wins.
  - Forced B grant: A is stalled exactly one cycle, and wait_cnt returns to 0.
  - MAX_WAIT=1: B wins every second cycle under continuous A load.

Test Plan:
- A-only: A writes 0x1234 to 0x10, then reads 0x10 back-to-back -> a_ready=1 both cycles; a_rvalid=1 one cycle after the read with a_rdata=0x1234; b_* outputs stay 0.
- B-only load: B writes 0xA, 0xB, 0xC to 0x0, 0x8, 0x10 on consecutive cycles, then reads 0x8 -> three accepts in 3 cycles; b_rdata=0xB one cycle after the read accept.
- Contention, MAX_WAIT=4: a_req and b_req held high continuously -> A accepted cycles 0-3; B accepted cycle 4 with b_forced=1; A again cycles 5-8; B at cycle 9; pattern repeats.
- Withdrawal: B waits 3 cycles under A load, drops b_req for 1 cycle, reasserts -> wait_cnt restarts at 0; next B win is 4 cycles after reassertion.
- Response routing: A reads 0x20 (holds 0x55) at N, B reads 0x28 (holds 0x66) at N+1 -> a_rvalid/a_rdata=0x55 at N+1; b_rvalid/b_rdata=0x66 at N+2; no cross-delivery.
- Reset mid-operation: A read accepted, reset asserted before the next clock edge -> all outputs 0 immediately; after release, no a_rvalid pulse and wait_cnt=0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter onto one single-port synchronous data memory: fixed priority to A, wait counter forces B.
// One access per cycle, read data one cycle after accept; rvalid is a pulse with no backpressure.
module dmem_arbiter #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 64,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ready,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ready,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              b_forced
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

  owner_t     r_rd_owner;
  logic [3:0] r_wait_cnt;
  logic       w_force;
  logic       w_gnt_a;
  logic       w_gnt_b;

  // Every grant is qualified by reset so nothing is accepted while it is held low.
  assign w_force = reset & b_req & (r_wait_cnt == MAX_CNT);
  assign w_gnt_a = reset & a_req & ~w_force;
  assign w_gnt_b = reset & b_req & (w_force | ~a_req);

  assign a_ready  = w_gnt_a;
  assign b_ready  = w_gnt_b;
  assign b_forced = w_force;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_gnt_a) begin
      mem_en    = 1'b1;
      mem_we    = a_we;
      mem_addr  = a_addr;
      mem_wdata = a_wdata;
    end else if (w_gnt_b) begin
      mem_en    = 1'b1;
      mem_we    = b_we;
      mem_addr  = b_addr;
      mem_wdata = b_wdata;
    end
  end

  assign a_rvalid = (r_rd_owner == OWN_A);
  assign b_rvalid = (r_rd_owner == OWN_B);
  assign a_rdata  = (r_rd_owner == OWN_A) ? mem_rdata : '0;
  assign b_rdata  = (r_rd_owner == OWN_B) ? mem_rdata : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_owner <= OWN_NONE;
      r_wait_cnt <= 4'd0;
    end else begin
      if (w_gnt_a && !a_we) begin
        r_rd_owner <= OWN_A;
      end else if (w_gnt_b && !b_we) begin
        r_rd_owner <= OWN_B;
      end else begin
        r_rd_owner <= OWN_NONE;
      end

      if (!b_req || w_gnt_b) begin
        r_wait_cnt <= 4'd0;
      end else if (r_wait_cnt != MAX_CNT) begin
        r_wait_cnt <= r_wait_cnt + 4'd1;
      end
    end
  end

endmodule
